// File: rtl/sqrt_sched_pkg.sv
// rtl/sqrt_sched_pkg.sv - shared types and constants for the sqrt core scheduler
package sqrt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  // Quiet NaN returned when the core never reports a result
  localparam logic [15:0] QNAN_FP16 = 16'hFE00;

  // The core holds RESULT high while idle, so RESULT is trusted only from here on
  localparam int MIN_CAPTURE_CNT = 3;

  // Counter value at which a normal/denormal operand finishes its iterations
  localparam int CORE_DONE_CNT = 14;

endpackage

// File: rtl/sqrt_sched_if.sv
// rtl/sqrt_sched_if.sv - requester and response channels of the sqrt scheduler
interface sqrt_sched_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    REQ_VALID;
  logic [16*N_REQ-1:0] REQ_DATA;
  logic [N_REQ-1:0]    REQ_READY;

  logic                RSP_VALID;
  logic                RSP_READY;
  logic [ID_W-1:0]     RSP_ID;
  logic [15:0]         RSP_DATA;
  logic                RSP_NAN;
  logic                RSP_PINF;
  logic                RSP_NINF;
  logic                RSP_TIMEOUT;

  // Requester fabric side
  modport master (
    output REQ_VALID, REQ_DATA, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_ID, RSP_DATA,
    input  RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT
  );

  // Scheduler side
  modport slave (
    input  REQ_VALID, REQ_DATA, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_ID, RSP_DATA,
    output RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT
  );

endinterface

// File: rtl/sqrt_sched_rr_arbiter.sv
// rtl/sqrt_sched_rr_arbiter.sv - combinational round-robin grant from a pointer
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Cyclic search starting at ptr; first requester found wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sqrt_sched.sv
// rtl/sqrt_sched.sv - round-robin sharing of one sqrt2 fp16 core among requesters
module sqrt_sched
  import sqrt_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  sqrt_sched_if.slave  bus,
  inout  wire  [15:0]  CORE_IO,
  output logic         CORE_ENABLE,
  input  logic         CORE_RESULT,
  input  logic         CORE_IS_NAN,
  input  logic         CORE_IS_PINF,
  input  logic         CORE_IS_NINF
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(MIN_CAPTURE_CNT);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
  localparam logic [ID_W-1:0]  LAST_ID = ID_W'(N_REQ - 1);

  sched_state_t     state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      op_q;
  logic [ID_W-1:0]  id_q;

  logic [15:0]      rsp_data_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic             rsp_nan_q, rsp_pinf_q, rsp_ninf_q, rsp_tmo_q;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic [N_REQ-1:0] req_ready;
  logic             accept, capture, abort, drive_bus, core_en;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (bus.REQ_VALID),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Only DRIVE puts the operand on the shared bus; the core owns it from counter 2
  assign CORE_IO     = drive_bus ? op_q : 16'hzzzz;
  assign CORE_ENABLE = core_en;

  assign bus.REQ_READY   = req_ready;
  assign bus.RSP_VALID   = (state_q == RESP);
  assign bus.RSP_ID      = rsp_id_q;
  assign bus.RSP_DATA    = rsp_data_q;
  assign bus.RSP_NAN     = rsp_nan_q;
  assign bus.RSP_PINF    = rsp_pinf_q;
  assign bus.RSP_NINF    = rsp_ninf_q;
  assign bus.RSP_TIMEOUT = rsp_tmo_q;

  // Next state and core/handshake strobes; everything is masked while reset is low
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    drive_bus = 1'b0;
    core_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (RST_N && (|bus.REQ_VALID)) begin
          req_ready = grant;
          accept    = 1'b1;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        core_en   = RST_N;
        drive_bus = RST_N;
        state_d   = WAIT;
      end
      WAIT: begin
        core_en = RST_N;
        if ((cnt_q >= CAP_CNT) && CORE_RESULT) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (cnt_q == TMO_CNT) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.RSP_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, operation counter and response registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      op_q       <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_nan_q  <= 1'b0;
      rsp_pinf_q <= 1'b0;
      rsp_ninf_q <= 1'b0;
      rsp_tmo_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        op_q     <= bus.REQ_DATA[{grant_idx, 4'b0000} +: 16];
        id_q     <= grant_idx;
        rr_ptr_q <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
        cnt_q    <= '0;
      end else if (state_q == DRIVE) begin
        cnt_q <= CNT_W'(1);
      end else if ((state_q == WAIT) && (cnt_q != TMO_CNT)) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (capture) begin
        rsp_data_q <= CORE_IO;
        rsp_id_q   <= id_q;
        rsp_nan_q  <= CORE_IS_NAN;
        rsp_pinf_q <= CORE_IS_PINF;
        rsp_ninf_q <= CORE_IS_NINF;
        rsp_tmo_q  <= 1'b0;
      end else if (abort) begin
        rsp_data_q <= QNAN_FP16;
        rsp_id_q   <= id_q;
        rsp_nan_q  <= 1'b1;
        rsp_pinf_q <= 1'b0;
        rsp_ninf_q <= 1'b0;
        rsp_tmo_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_sched.sv
// tb/tb_sqrt_sched.sv - directed self-checking bench for sqrt_sched with a behavioural sqrt2 stub
module tb_sqrt_sched;
  import sqrt_sched_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  wire  [15:0] core_io;
  logic        core_en, core_result, core_nan, core_pinf, core_ninf;
  logic [15:0] opnd [N];

  sqrt_sched_if #(.N_REQ(N)) bus ();
  assign bus.REQ_DATA = {opnd[3], opnd[2], opnd[1], opnd[0]};

  sqrt_sched #(.N_REQ(N), .TIMEOUT(32)) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .bus          (bus),
    .CORE_IO      (core_io),
    .CORE_ENABLE  (core_en),
    .CORE_RESULT  (core_result),
    .CORE_IS_NAN  (core_nan),
    .CORE_IS_PINF (core_pinf),
    .CORE_IS_NINF (core_ninf)
  );

  // sqrt2 stub: counter reset by ENABLE=0, operand latched at counter 0, drives bus from 2
  logic [4:0]  ccnt = '0;
  logic [15:0] c_op = '0;
  logic        stub_dead = 1'b0;
  logic [15:0] c_res;
  logic        c_nan, c_pinf, c_ninf;
  int          c_done;

  function automatic void core_fn(input logic [15:0] a, output logic [15:0] r,
                                  output logic n, output logic p, output logic ni, output int done);
    n = 1'b0; p = 1'b0; ni = 1'b0; done = CORE_DONE_CNT;
    case (a)
      16'h4400: r = 16'h4000;
      16'h3C00: r = 16'h3C00;
      16'h4880: r = 16'h4200;
      16'h4C00: r = 16'h4400;
      16'h5220: r = 16'h4700;
      16'h7C00: begin r = 16'h7C00; p = 1'b1; done = 3; end
      16'h0000: begin r = 16'h0000; done = 3; end
      default:  begin r = 16'hFE00; n = 1'b1; done = 3; end
    endcase
  endfunction

  always @(posedge clk) begin
    if (!core_en) ccnt <= '0;
    else begin
      if (ccnt == 5'd0) c_op <= core_io;
      if (ccnt != 5'd31) ccnt <= ccnt + 5'd1;
    end
  end

  always_comb core_fn(c_op, c_res, c_nan, c_pinf, c_ninf, c_done);

  assign core_io     = (core_en && ccnt >= 5'd2) ? c_res : 16'hzzzz;
  assign core_result = stub_dead ? 1'b0 : ((ccnt <= 5'd2) || (int'(ccnt) >= c_done));
  assign core_nan    = c_nan;
  assign core_pinf   = c_pinf;
  assign core_ninf   = c_ninf;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus only: issue one request mask, wait for the response, accept it
  task automatic run_op(input logic [3:0] mask, output int lat, output logic [3:0] rdy,
                        output logic [1:0] rid, output logic [15:0] rdata, output logic [3:0] fl);
    bus.REQ_VALID = mask;
    #1;
    rdy = bus.REQ_READY;
    @(posedge clk); #1;
    bus.REQ_VALID = '0;
    lat = 0;
    while (bus.RSP_VALID !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (bus.RSP_VALID !== 1'b1) lat = -1;
    rid   = bus.RSP_ID;
    rdata = bus.RSP_DATA;
    fl    = {bus.RSP_NAN, bus.RSP_PINF, bus.RSP_NINF, bus.RSP_TIMEOUT};
    bus.RSP_READY = 1'b1;
    @(posedge clk); #1;
    bus.RSP_READY = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stub_dead = 1'b0;
    bus.RSP_READY = 1'b0;
    bus.REQ_VALID = 4'b1111;
    for (int i = 0; i < N; i++) opnd[i] = 16'h4400;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.RSP_VALID !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b exp 0", bus.RSP_VALID); end
    n_vec++; if ({bus.RSP_ID, bus.RSP_DATA} !== 18'h0) begin n_err++; $display("FAIL reset_rsp_id_data got %h/%h exp 0/0000", bus.RSP_ID, bus.RSP_DATA); end
    n_vec++; if ({bus.RSP_NAN, bus.RSP_PINF, bus.RSP_NINF, bus.RSP_TIMEOUT} !== 4'b0) begin n_err++; $display("FAIL reset_flags got %b%b%b%b exp 0000", bus.RSP_NAN, bus.RSP_PINF, bus.RSP_NINF, bus.RSP_TIMEOUT); end
    n_vec++; if ({core_en, bus.REQ_READY} !== 5'b0) begin n_err++; $display("FAIL reset_en_ready got %b/%b exp 0/0000", core_en, bus.REQ_READY); end
    bus.REQ_VALID = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal();
    int lat; logic [3:0] rdy; logic [1:0] rid; logic [15:0] d; logic [3:0] fl;
    opnd[0] = 16'h4400;
    run_op(4'b0001, lat, rdy, rid, d, fl);
    n_vec++; if (lat !== 15) begin n_err++; $display("FAIL normal_latency got %0d exp 15", lat); end
    n_vec++; if (rdy !== 4'b0001) begin n_err++; $display("FAIL normal_ready got %b exp 0001", rdy); end
    n_vec++; if (d !== 16'h4000) begin n_err++; $display("FAIL normal_data got %h exp 4000", d); end
    n_vec++; if ({rid, fl} !== 6'b0) begin n_err++; $display("FAIL normal_id_flags got %0d/%b exp 0/0000", rid, fl); end
  endtask

  task automatic test_special();
    logic [1:0]  ids [3] = '{2'd1, 2'd2, 2'd3};
    logic [15:0] ops [3] = '{16'hBC00, 16'h7C00, 16'h0000};
    logic [15:0] exd [3] = '{16'hFE00, 16'h7C00, 16'h0000};
    logic [3:0]  exf [3] = '{4'b1000, 4'b0100, 4'b0000};
    int lat; logic [3:0] rdy; logic [1:0] rid; logic [15:0] d; logic [3:0] fl;
    for (int i = 0; i < 3; i++) begin
      opnd[ids[i]] = ops[i];
      run_op(4'b0001 << ids[i], lat, rdy, rid, d, fl);
      n_vec++; if (lat !== 4) begin n_err++; $display("FAIL special_latency[%h] got %0d exp 4", ops[i], lat); end
      n_vec++; if (rid !== ids[i]) begin n_err++; $display("FAIL special_id[%h] got %0d exp %0d", ops[i], rid, ids[i]); end
      n_vec++; if ({d, fl} !== {exd[i], exf[i]}) begin n_err++; $display("FAIL special_result[%h] got %h/%b exp %h/%b", ops[i], d, fl, exd[i], exf[i]); end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  order [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
    logic [15:0] exd   [4] = '{16'h3C00, 16'h4200, 16'h4400, 16'h4700};
    int t;
    opnd[0] = 16'h3C00; opnd[1] = 16'h4880; opnd[2] = 16'h4C00; opnd[3] = 16'h5220;
    bus.REQ_VALID = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      t = 0;
      while (bus.RSP_VALID !== 1'b1 && t < 60) begin @(posedge clk); #1; t++; end
      n_vec++; if (bus.RSP_VALID !== 1'b1 || bus.RSP_ID !== order[k]) begin n_err++; $display("FAIL rr_order[%0d] got valid %b id %0d exp id %0d", k, bus.RSP_VALID, bus.RSP_ID, order[k]); end
      n_vec++; if (bus.RSP_DATA !== exd[order[k]]) begin n_err++; $display("FAIL rr_data[%0d] got %h exp %h", k, bus.RSP_DATA, exd[order[k]]); end
      if (k == 4) bus.REQ_VALID = 4'b1101;
      if (k == 8) bus.REQ_VALID = 4'b0000;
      bus.RSP_READY = 1'b1;
      @(posedge clk); #1;
      bus.RSP_READY = 1'b0;
    end
  endtask

  task automatic test_back_pressure();
    int t;
    opnd[3] = 16'h0000;
    bus.REQ_VALID = 4'b1000;
    @(posedge clk); #1;
    bus.REQ_VALID = 4'b0010;
    t = 0;
    while (bus.RSP_VALID !== 1'b1 && t < 60) begin @(posedge clk); #1; t++; end
    n_vec++; if (t !== 4) begin n_err++; $display("FAIL bp_latency got %0d exp 4", t); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_vec++; if ({bus.RSP_VALID, bus.RSP_ID, bus.RSP_DATA, bus.RSP_NAN, bus.RSP_PINF, bus.RSP_NINF, bus.RSP_TIMEOUT} !== {1'b1, 2'd3, 16'h0000, 4'b0000})
        begin n_err++; $display("FAIL bp_hold[%0d] got v%b id%0d d%h", c, bus.RSP_VALID, bus.RSP_ID, bus.RSP_DATA); end
      n_vec++; if ({core_en, bus.REQ_READY} !== 5'b0) begin n_err++; $display("FAIL bp_quiet[%0d] got en %b ready %b exp 0/0000", c, core_en, bus.REQ_READY); end
    end
    bus.RSP_READY = 1'b1;
    @(posedge clk); #1;
    bus.RSP_READY = 1'b0;
    n_vec++; if ({bus.RSP_VALID, bus.REQ_READY} !== 5'b0_0010) begin n_err++; $display("FAIL bp_release got valid %b ready %b exp 0/0010", bus.RSP_VALID, bus.REQ_READY); end
    bus.REQ_VALID = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int lat; logic [3:0] rdy; logic [1:0] rid; logic [15:0] d; logic [3:0] fl;
    stub_dead = 1'b1;
    opnd[0] = 16'h4400;
    run_op(4'b0001, lat, rdy, rid, d, fl);
    stub_dead = 1'b0;
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL timeout_latency got %0d exp 33", lat); end
    n_vec++; if ({rid, d} !== {2'd0, 16'hFE00}) begin n_err++; $display("FAIL timeout_data got %0d/%h exp 0/fe00", rid, d); end
    n_vec++; if (fl !== 4'b1001) begin n_err++; $display("FAIL timeout_flags got %b exp 1001", fl); end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [3:0] rdy; logic [1:0] rid; logic [15:0] d; logic [3:0] fl;
    logic seen;
    opnd[2] = 16'h4400;
    bus.REQ_VALID = 4'b0100;
    @(posedge clk); #1;
    bus.REQ_VALID = 4'b0000;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_vec++; if ({bus.RSP_VALID, core_en, bus.REQ_READY} !== 6'b0) begin n_err++; $display("FAIL midrst_ctrl got v%b en%b rdy%b exp 0/0/0000", bus.RSP_VALID, core_en, bus.REQ_READY); end
    n_vec++; if ({bus.RSP_ID, bus.RSP_DATA, bus.RSP_NAN, bus.RSP_PINF, bus.RSP_NINF, bus.RSP_TIMEOUT} !== 22'h0)
      begin n_err++; $display("FAIL midrst_rsp got id%0d d%h flags %b%b%b%b exp 0/0000/0000", bus.RSP_ID, bus.RSP_DATA, bus.RSP_NAN, bus.RSP_PINF, bus.RSP_NINF, bus.RSP_TIMEOUT); end
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.RSP_VALID === 1'b1) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_response got %b exp 0", seen); end
    opnd[1] = 16'h4880;
    opnd[3] = 16'h5220;
    run_op(4'b1010, lat, rdy, rid, d, fl);
    n_vec++; if (rdy !== 4'b0010) begin n_err++; $display("FAIL midrst_ptr_grant got %b exp 0010", rdy); end
    n_vec++; if ({rid, d, fl} !== {2'd1, 16'h4200, 4'b0000}) begin n_err++; $display("FAIL midrst_result got %0d/%h/%b exp 1/4200/0000", rid, d, fl); end
    n_vec++; if (lat !== 15) begin n_err++; $display("FAIL midrst_latency got %0d exp 15", lat); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_round_robin();
    test_back_pressure();
    test_timeout();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
